wishbone_ctl_mc: RTL and testbench

Parametrised multi-channel Wishbone slave controller, the successor to the single-register Wishbone control block. It decodes a classic Wishbone request into one of `NUM_CH` downstream channels. Each channel uses a req/ready handshake with byte-select pass-through. The block returns ack on completion and err on an address miss or a downstream timeout. It sits between the caravel-side Wishbone bus and the enclave accelerator's configuration/data channels.

---
 rtl/wishbone_ctl_mc.sv | 182 ++++++++++++++++++
 tb/tb_wishbone_ctl_mc.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_ctl_mc.sv
// wishbone_ctl_mc: multi-channel Wishbone slave controller.
// Decodes a classic Wishbone request into one of NUM_CH downstream req/ready
// channels. It answers with a one-cycle ack on completion, or with a one-cycle
// err on an address miss or a downstream timeout.
module wishbone_ctl_mc #(
  parameter int          DATA_W    = 32,
  parameter int          NUM_CH    = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          ADDR_LSB  = 2,
  parameter int          TIMEOUT   = 15
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [DATA_W/8-1:0]      wbs_sel_i,
  input  logic [DATA_W-1:0]        wbs_dat_i,
  input  logic [31:0]              wbs_adr_i,
  output logic                     wbs_ack_o,
  output logic                     wbs_err_o,
  output logic [DATA_W-1:0]        wbs_dat_o,
  output logic [NUM_CH-1:0]        ch_req_o,
  output logic                     ch_we_o,
  output logic [DATA_W/8-1:0]      ch_sel_o,
  output logic [DATA_W-1:0]        ch_wdata_o,
  input  logic [NUM_CH-1:0]        ch_ready_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata_i
);

  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TAG_LSB = ADDR_LSB + CH_W;
  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SEL_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [NUM_CH-1:0] req_next;
  logic              ack_next;
  logic              err_next;
  logic [DATA_W-1:0] dat_next;
  logic              we_next;
  logic [SEL_W-1:0]  sel_next;
  logic [DATA_W-1:0] wdata_next;

  // Address decode of the incoming request.
  logic              req;
  logic              hit;
  logic [CH_W-1:0]   adr_ch;
  logic [NUM_CH-1:0] adr_onehot;

  // Word-offset bits take no part in the decode.
  logic unused_adr_bits;
  assign unused_adr_bits = ^wbs_adr_i[ADDR_LSB-1:0];

  assign req    = wbs_stb_i & wbs_cyc_i;
  assign adr_ch = wbs_adr_i[ADDR_LSB +: CH_W];
  assign hit    = (wbs_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]) &&
                  ({1'b0, adr_ch} < (CH_W + 1)'(NUM_CH));

  // The registered one-hot request selects the active channel. It is zero
  // outside REQ, so ready or data from any other channel, or ready arriving
  // in any other state, cannot complete the transfer.
  logic              ready_hit;
  logic [DATA_W-1:0] rdata_masked [NUM_CH];
  logic [DATA_W-1:0] rdata_sel;

  assign ready_hit = |(ch_ready_i & ch_req_o);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign adr_onehot[gi]   = (adr_ch == CH_W'(gi));
    assign rdata_masked[gi] = ch_req_o[gi] ? ch_rdata_i[gi*DATA_W +: DATA_W] : '0;
  end

  // OR-combine the masked read data; at most one channel contributes.
  always_comb begin
    rdata_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      rdata_sel = rdata_sel | rdata_masked[k];
    end
  end

  // Next-state and next-output logic of the transfer FSM.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_next   = '0;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    dat_next   = wbs_dat_o;
    we_next    = ch_we_o;
    sel_next   = ch_sel_o;
    wdata_next = ch_wdata_o;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            state_next = REQ;
            req_next   = adr_onehot;
            we_next    = wbs_we_i;
            sel_next   = wbs_sel_i;
            wdata_next = wbs_dat_i;
            cnt_next   = '0;
          end else begin
            state_next = RESP;
            err_next   = 1'b1;
          end
        end
      end
      REQ: begin
        if (!wbs_cyc_i) begin
          // Master abort: drop the channel request silently.
          state_next = IDLE;
        end else if (ready_hit) begin
          // Ready wins over a timeout that falls in the same cycle.
          state_next = RESP;
          ack_next   = 1'b1;
          if (!ch_we_o) begin
            dat_next = rdata_sel;
          end
        end else if ((TIMEOUT > 0) && (cnt == CNT_W'(TIMEOUT - 1))) begin
          state_next = RESP;
          err_next   = 1'b1;
          if (!ch_we_o) begin
            dat_next = '0;
          end
        end else begin
          req_next = ch_req_o;
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered outputs, latched channel fields and the timeout counter.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt        <= '0;
      ch_req_o   <= '0;
      wbs_ack_o  <= 1'b0;
      wbs_err_o  <= 1'b0;
      wbs_dat_o  <= '0;
      ch_we_o    <= 1'b0;
      ch_sel_o   <= '0;
      ch_wdata_o <= '0;
    end else begin
      cnt        <= cnt_next;
      ch_req_o   <= req_next;
      wbs_ack_o  <= ack_next;
      wbs_err_o  <= err_next;
      wbs_dat_o  <= dat_next;
      ch_we_o    <= we_next;
      ch_sel_o   <= sel_next;
      ch_wdata_o <= wdata_next;
    end
  end

endmodule

// File: tb/tb_wishbone_ctl_mc.sv
// Testbench for wishbone_ctl_mc: a vector table, hand-written corner-case
// sequences and random back-to-back traffic. Expected responses are queued
// when a request is driven and popped when ack/err appears.
module tb_wishbone_ctl_mc;
  localparam int NUM_CH  = 4;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic [31:0] wbs_adr_i = '0;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic [31:0] wbs_dat_o;
  logic [3:0]  ch_req_o;
  logic        ch_we_o;
  logic [3:0]  ch_sel_o;
  logic [31:0] ch_wdata_o;
  logic [3:0]  ch_ready_i = '0;
  logic [127:0] ch_rdata_i = '0;

  // Three-channel instance for the channel-range miss.
  logic        ack3;
  logic        err3;
  logic [31:0] dat3;
  logic [2:0]  req3;
  logic        we3;
  logic [3:0]  sel3;
  logic [31:0] wdata3;

  always #5 clk = ~clk;

  wishbone_ctl_mc #(
    .DATA_W(32), .NUM_CH(NUM_CH), .BASE_ADDR(32'h3000_0000), .ADDR_LSB(2), .TIMEOUT(TIMEOUT)
  ) u_dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_dat_o(wbs_dat_o),
    .ch_req_o(ch_req_o), .ch_we_o(ch_we_o), .ch_sel_o(ch_sel_o), .ch_wdata_o(ch_wdata_o),
    .ch_ready_i(ch_ready_i), .ch_rdata_i(ch_rdata_i)
  );

  wishbone_ctl_mc #(
    .DATA_W(32), .NUM_CH(3), .BASE_ADDR(32'h3000_0000), .ADDR_LSB(2), .TIMEOUT(TIMEOUT)
  ) u_dut3 (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(ack3), .wbs_err_o(err3), .wbs_dat_o(dat3),
    .ch_req_o(req3), .ch_we_o(we3), .ch_sel_o(sel3), .ch_wdata_o(wdata3),
    .ch_ready_i(ch_ready_i[2:0]), .ch_rdata_i(ch_rdata_i[95:0])
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          delay;     // REQ cycles before ready; -1 = never ready
    logic [31:0] rdata;
    logic        exp_err;
    int          exp_cycle; // cycle of ack/err, request seen in cycle 0
    logic [31:0] exp_dat;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    int          cycle;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[11];
  int          n_checks = 0;
  int          n_errs = 0;
  logic [31:0] model_dat = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_rdata(input int ch, input logic [31:0] val);
    for (int k = 0; k < NUM_CH; k++) begin
      ch_rdata_i[k*32 +: 32] = (k == ch) ? val : (~val ^ 32'(k + 1));
    end
  endtask

  // Reference behaviour of one transfer given the channel's ready delay.
  function automatic void model(input logic we, input logic [31:0] adr, input int delay,
                                input logic [31:0] rdata, output logic err, output int cyc,
                                output logic [31:0] dat);
    logic hit;
    hit = (adr[31:4] == 28'h300_0000);
    if (!hit) begin
      err = 1'b1; cyc = 1; dat = model_dat;
    end else if (delay >= 0 && delay < TIMEOUT) begin
      err = 1'b0; cyc = delay + 2; dat = we ? model_dat : rdata;
    end else begin
      err = 1'b1; cyc = TIMEOUT + 1; dat = we ? model_dat : 32'h0;
    end
    model_dat = dat;
  endfunction

  // Drive one transfer starting just after a rising edge (cycle 0), play the
  // addressed channel with decoy ready on the others, and check the response.
  task automatic xfer(input logic t_we, input logic [31:0] t_adr, input logic [3:0] t_sel,
                      input logic [31:0] t_dat, input int delay, input logic [31:0] rdata,
                      input logic exp_err, input int exp_cycle, input logic [31:0] exp_dat);
    exp_t       e;
    int         n;
    bit         done;
    int         ch;
    bit         hit;
    logic [3:0] onehot;
    ch     = int'(t_adr[3:2]);
    hit    = (t_adr[31:4] == 28'h300_0000);
    onehot = hit ? 4'(1 << ch) : 4'b0;
    e.err = exp_err; e.dat = exp_dat; e.cycle = exp_cycle;
    sb_q.push_back(e);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = t_we;
    wbs_adr_i = t_adr; wbs_sel_i = t_sel; wbs_dat_i = t_dat;
    ch_ready_i = 4'($urandom);
    set_rdata(ch, rdata);
    @(negedge clk);
    check("idle_quiet", {wbs_ack_o, wbs_err_o, ch_req_o}, 6'b0);
    n = 0;
    done = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      ch_ready_i = 4'($urandom) & ~onehot;
      if (hit && delay >= 0 && n == delay + 1) ch_ready_i = ch_ready_i | onehot;
      @(negedge clk);
      if (wbs_ack_o || wbs_err_o) begin
        done = 1;
        e = sb_q.pop_front();
        check("resp_excl", {31'b0, wbs_ack_o & wbs_err_o}, 32'b0);
        check("resp_kind", {wbs_ack_o, wbs_err_o}, {~e.err, e.err});
        check("resp_cycle", n, e.cycle);
        check("resp_data", wbs_dat_o, e.dat);
        check("resp_req_clear", ch_req_o, 4'b0);
        $display("xfer %s adr=%h sel=%h wdat=%h delay=%0d -> cycle=%0d ack=%0b err=%0b dat=%h",
                 t_we ? "WR" : "RD", t_adr, t_sel, t_dat, delay, n, wbs_ack_o, wbs_err_o, wbs_dat_o);
      end else begin
        check("ch_req", ch_req_o, onehot);
        if (hit) check("ch_fields", {ch_we_o, ch_sel_o, ch_wdata_o}, {t_we, t_sel, t_dat});
      end
    end
    if (!done) begin
      n_checks++;
      n_errs++;
      $display("FAIL resp_timeout: no ack/err within 40 cycles for adr %h", t_adr);
      void'(sb_q.pop_front());
    end
    @(posedge clk); #1;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; ch_ready_i = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        r_we;
    logic [31:0] r_adr;
    logic [3:0]  r_sel;
    logic [31:0] r_dat;
    logic [31:0] r_rdata;
    int          r_delay;
    int          r_ch;
    logic        e_err;
    int          e_cyc;
    logic [31:0] e_dat;

    //           we    adr            sel    dat            dly rdata          err   cyc dat
    vecs[0]  = '{1'b0, 32'h3000_0008, 4'hF, 32'h0,         0,  32'hA5A5_0002, 1'b0, 2,  32'hA5A5_0002};
    vecs[1]  = '{1'b1, 32'h3000_0004, 4'h6, 32'h1234_5678, 3,  32'hFFFF_FFFF, 1'b0, 5,  32'hA5A5_0002};
    vecs[2]  = '{1'b0, 32'h3000_000C, 4'hF, 32'h0,         -1, 32'h7777_7777, 1'b1, 16, 32'h0};
    vecs[3]  = '{1'b0, 32'h3000_000C, 4'hF, 32'h0,         14, 32'hDEAD_BEEF, 1'b0, 16, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 32'h3000_1000, 4'hF, 32'h0,         0,  32'h1212_1212, 1'b1, 1,  32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 32'h3000_0000, 4'h0, 32'h55AA_55AA, 1,  32'h3434_3434, 1'b0, 3,  32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, 32'h3000_000C, 4'hF, 32'h0102_0304, -1, 32'h5656_5656, 1'b1, 16, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b0, 32'h3000_0000, 4'hF, 32'h0,         2,  32'h0BAD_F00D, 1'b0, 4,  32'h0BAD_F00D};
    vecs[8]  = '{1'b0, 32'h3000_000B, 4'h3, 32'h0,         0,  32'h1111_2222, 1'b0, 2,  32'h1111_2222};
    vecs[9]  = '{1'b1, 32'h4000_0000, 4'hF, 32'h9999_0000, 0,  32'h0,         1'b1, 1,  32'h1111_2222};
    vecs[10] = '{1'b0, 32'h3000_0004, 4'hF, 32'h0,         13, 32'h89AB_CDEF, 1'b0, 15, 32'h89AB_CDEF};

    // Reset values.
    #1 wb_rst_i = 1'b1;
    #1;
    check("rst_ctl", {wbs_ack_o, wbs_err_o, ch_req_o, ch_we_o, ch_sel_o}, 11'b0);
    check("rst_wdata", ch_wdata_o, 32'h0);
    check("rst_rdata", wbs_dat_o, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    wb_rst_i = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) begin
      xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, vecs[i].delay, vecs[i].rdata,
           vecs[i].exp_err, vecs[i].exp_cycle, vecs[i].exp_dat);
      model_dat = vecs[i].exp_dat;
    end

    // Master abort in REQ: no response, then a normal read on ch0.
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h3000_0000; wbs_sel_i = 4'hF; ch_ready_i = '0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("abort_req", ch_req_o, 4'b0001);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_quiet", {wbs_ack_o, wbs_err_o, ch_req_o}, 6'b0);
    end
    @(posedge clk); #1;
    model(1'b0, 32'h3000_0000, 0, 32'hC0DE_0000, e_err, e_cyc, e_dat);
    xfer(1'b0, 32'h3000_0000, 4'hF, 32'h0, 0, 32'hC0DE_0000, e_err, e_cyc, e_dat);

    // Asynchronous reset in the middle of a REQ phase.
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'h3000_0004; wbs_sel_i = 4'hF; wbs_dat_i = 32'hCAFE_F00D; ch_ready_i = '0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rst_pre_req", ch_req_o, 4'b0010);
    #2 wb_rst_i = 1'b1;
    #1;
    check("rst_async_ctl", {wbs_ack_o, wbs_err_o, ch_req_o, ch_we_o, ch_sel_o}, 11'b0);
    check("rst_async_wdata", ch_wdata_o, 32'h0);
    check("rst_async_rdata", wbs_dat_o, 32'h0);
    model_dat = 32'h0;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    wb_rst_i = 1'b0;
    @(negedge clk);
    check("rst_release_quiet", {wbs_ack_o, wbs_err_o, ch_req_o}, 6'b0);
    @(posedge clk); #1;

    // Channel 3 on a three-channel instance is a miss; the four-channel one hits.
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h3000_000C; wbs_sel_i = 4'hF; ch_ready_i = '0;
    set_rdata(3, 32'h3333_0003);
    @(posedge clk); #1;
    @(negedge clk);
    check("nch3_err", {ack3, err3}, 2'b01);
    check("nch3_req", req3, 3'b0);
    check("main_ch3_req", ch_req_o, 4'b1000);
    ch_ready_i = 4'b1000;
    @(posedge clk); #1;
    @(negedge clk);
    check("nch3_pulse", {ack3, err3}, 2'b0);
    check("main_ch3_ack", {wbs_ack_o, wbs_err_o}, 2'b10);
    check("main_ch3_data", wbs_dat_o, 32'h3333_0003);
    model_dat = 32'h3333_0003;
    @(posedge clk); #1;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; ch_ready_i = '0;
    @(posedge clk); #1;

    // Random back-to-back traffic against the reference model.
    for (int i = 0; i < 100; i++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_ch    = int'($urandom_range(0, 3));
      r_adr   = 32'h3000_0000 | 32'(r_ch << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) r_adr = r_adr ^ (32'h1 << $urandom_range(4, 31));
      r_delay = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 5));
      r_sel   = 4'($urandom);
      r_dat   = $urandom;
      r_rdata = $urandom;
      model(r_we, r_adr, r_delay, r_rdata, e_err, e_cyc, e_dat);
      xfer(r_we, r_adr, r_sel, r_dat, r_delay, r_rdata, e_err, e_cyc, e_dat);
    end

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
